cmd_host: RTL and testbench
===========================

CMD_HOST -- requirements
Module: cmd_host

Interface
REQ-001 Parameters:
- ENTRIES, 384, number of bytes returned by a dump command.
- LOG2, 9, width of the dump byte counter.
- TIMEOUT, 65536, idle cycles tolerated between response bytes.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 snd_cmd  in  1  one-cycle request to issue cmd; ignored unless busy=0.
REQ-006 cmd  in  16  command word: [15:14] opcode, [13:8] address/channel, [7:0] data.
REQ-007 tx_data  out  8  byte handed to the UART transmitter.
REQ-008 trmt  out  1  one-cycle strobe that starts transmission of tx_data.
REQ-009 tx_done  in  1  transmitter has finished the current byte.
REQ-010 rx_rdy  in  1  UART receiver holds a valid byte.
REQ-011 rx_data  in  8  received byte.
REQ-012 clr_rx_rdy  out  1  one-cycle strobe acknowledging rx_data.
REQ-013 resp  out  8  most recently received response byte, registered.
REQ-014 resp_vld  out  1  one-cycle pulse when resp updates.
REQ-015 cmd_cmplt  out  1  one-cycle pulse when the transaction ends.
REQ-016 busy  out  1  high from snd_cmd acceptance until cmd_cmplt.
REQ-017 ack  out  1  registered at completion; 1 if a non-dump transaction's last byte was 8'hA5.
REQ-018 nack  out  1  registered at completion; 1 if the last byte was 8'hEE.
REQ-019 timeout  out  1  registered at completion; 1 if the transaction aborted on timeout.

Function
REQ-020 States are IDLE, TXH, TXL, RX.
REQ-021 IDLE, snd_cmd=1:
- latch cmd;
- drive tx_data=cmd[15:8] with trmt=1 in the same cycle;
- clear ack/nack/timeout;
- go to TXH.
REQ-022 TXH, tx_done=1: drive tx_data=cmd_latched[7:0], trmt=1; go to TXL.
REQ-023 TXL, tx_done=1: clear the byte counter and the timeout counter; go to RX.
REQ-024 tx_data shall hold its value between trmt and tx_done.
REQ-025 Expected byte count: ENTRIES when cmd_latched[15:14]=2'b10 (dump); otherwise 1.
REQ-026 RX, rx_rdy=1, on each byte:
- register resp=rx_data;
- pulse resp_vld and clr_rx_rdy;
- increment the byte counter;
- clear the timeout counter.
REQ-027 RX, on the byte that reaches the expected count:
- pulse cmd_cmplt in the cycle after resp_vld;
- set ack/nack per REQ-017/018 (both 0 for dump);
- go to IDLE.
REQ-028 RX, rx_rdy=0: timeout counter increments; on reaching TIMEOUT-1, set timeout=1, pulse cmd_cmplt, go to IDLE.
REQ-029 When rx_rdy=1 and the timeout terminal count occur in the same cycle, the byte wins; the timeout is not flagged.
REQ-030 rx_rdy asserted in IDLE, TXH or TXL shall be acknowledged (clr_rx_rdy) and discarded; resp_vld stays low.
REQ-031 snd_cmd while busy=1 shall be ignored with no effect on the latched cmd.
REQ-032 busy=1 in TXH, TXL and RX, and in the cmd_cmplt cycle.
REQ-033 The byte counter is LOG2+1 bits wide, so ENTRIES does not wrap it.
REQ-034 The timeout counter saturates and never wraps.
REQ-035 Latency from snd_cmd to the first trmt is 0 cycles (combinational from IDLE).
REQ-036 Latency from the final rx_rdy to cmd_cmplt is 1 cycle.

Reset
REQ-037 On rst_n=0 at posedge, from any state including mid-transaction:
- state goes to IDLE;
- tx_data=0, trmt=0, clr_rx_rdy=0;
- resp=0, resp_vld=0, cmd_cmplt=0, busy=0;
- ack=0, nack=0, timeout=0;
- all counters=0.
REQ-038 No cmd_cmplt pulse shall be produced for a transaction aborted by reset.

Structure
REQ-039 A shared package holds:
- the opcode constants: READ=2'b00, WRITE=2'b01, DUMP=2'b10;
- the response constants: ACK=8'hA5, NACK=8'hEE;
- the cmd_host state enum.
The same opcode and response constants are used by the command processor.
REQ-040 One sub-module, resp_timer (the saturating timeout counter with clear and terminal-count output), is natural.
REQ-041 The FSM and the byte counter shall be implemented in cmd_host.

Verification
REQ-042 Write: snd_cmd with cmd=16'h4706; tx_done 20 cycles after each trmt; reply 8'hA5 -> tx bytes 8'h47 then 8'h06; one resp_vld; cmd_cmplt with ack=1.
REQ-043 Read: cmd=16'h0700, reply 8'hAA -> resp=8'hAA, ack=0, nack=0, one cmd_cmplt.
REQ-044 Dump: cmd=16'h8100, 384 replies of incrementing bytes -> exactly 384 resp_vld pulses; cmd_cmplt one cycle after the 384th byte.
REQ-045 Bad opcode: cmd=16'hC000, reply 8'hEE -> nack=1, cmd_cmplt pulse.
REQ-046 Timeout: read command with no reply -> timeout=1 and cmd_cmplt exactly TIMEOUT cycles after entering RX. Same case with the byte arriving on the terminal cycle -> timeout=0.
REQ-047 Reset mid-dump at byte 100 -> all outputs at reset values next cycle; no cmd_cmplt. A following write completes normally.

Source files
------------

// File: rtl/cmd_host_pkg.sv
// Shared command-link constants: opcodes, response codes and the host FSM encoding.
// The command processor on the far side of the link uses the same opcode/response values.
package cmd_host_pkg;

  localparam logic [1:0] READ  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] DUMP  = 2'b10;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TXH  = 2'd1,
    TXL  = 2'd2,
    RX   = 2'd3
  } host_state_e;

endpackage

// File: rtl/cmd_host_resp_timer.sv
// Saturating idle-cycle counter for the response phase; tc flags the last tolerated idle cycle.
module resp_timer #(
  parameter int TIMEOUT = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/cmd_host.sv
// Host side of the UART command link: sends a two-byte command, then collects one reply
// byte (or ENTRIES bytes for a dump) and reports ack/nack/timeout at completion.
module cmd_host
  import cmd_host_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        cmd_cmplt,
  output logic        busy,
  output logic        ack,
  output logic        nack,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  localparam int CW = LOG2 + 1;

  host_state_e   state;
  logic [1:0]    op_l;
  logic [7:0]    lo_l;
  logic [7:0]    tx_byte;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] exp_cnt;
  logic          accept;
  logic          send_lo;
  logic          last_byte;
  logic          tmr_clr;
  logic          tmr_inc;
  logic          tmr_tc;

  // Handshakes: trmt starts a byte and tx_data holds until tx_done; rx_rdy is
  // acknowledged by clr_rx_rdy in the same cycle, in every state.
  always_comb begin
    accept     = (state == IDLE) && snd_cmd && !busy;
    send_lo    = (state == TXH) && tx_done;
    trmt       = accept || send_lo;
    tx_data    = tx_byte;
    if (accept) begin
      tx_data = cmd[15:8];
    end else if (send_lo) begin
      tx_data = lo_l;
    end
    clr_rx_rdy = rx_rdy;
    resp_vld   = (state == RX) && rx_rdy;
    exp_cnt    = (op_l == DUMP) ? CW'(ENTRIES) : CW'(1);
    last_byte  = resp_vld && ((byte_cnt + CW'(1)) == exp_cnt);
    tmr_clr    = ((state == TXL) && tx_done) || resp_vld;
    tmr_inc    = (state == RX) && !rx_rdy;
  end

  resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_l      <= 2'b00;
      lo_l      <= 8'h00;
      tx_byte   <= 8'h00;
      byte_cnt  <= '0;
      resp      <= 8'h00;
      cmd_cmplt <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cmd_cmplt <= 1'b0;
      // busy spans the completion cycle, so a new command cannot start until after it.
      if (cmd_cmplt) busy <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_l    <= cmd[15:14];
          lo_l    <= cmd[7:0];
          tx_byte <= cmd[15:8];
          ack     <= 1'b0;
          nack    <= 1'b0;
          timeout <= 1'b0;
          busy    <= 1'b1;
          state   <= TXH;
        end
        TXH: if (tx_done) begin
          tx_byte <= lo_l;
          state   <= TXL;
        end
        TXL: if (tx_done) begin
          byte_cnt <= '0;
          state    <= RX;
        end
        RX: begin
          // A byte arriving on the terminal idle cycle takes priority over the timeout.
          if (rx_rdy) begin
            resp     <= rx_data;
            byte_cnt <= byte_cnt + CW'(1);
            if (last_byte) begin
              ack       <= (op_l != DUMP) && (rx_data == ACK);
              nack      <= (op_l != DUMP) && (rx_data == NACK);
              cmd_cmplt <= 1'b1;
              state     <= IDLE;
            end
          end else if (tmr_tc) begin
            timeout   <= 1'b1;
            cmd_cmplt <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cmd_host.sv
// Bench for cmd_host: table-driven command transactions, randomized transactions checked
// against a transaction-level model, plus timeout and mid-dump reset sequences.
module tb_cmd_host;
  import cmd_host_pkg::*;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        cmd_cmplt;
  logic        busy;
  logic        ack;
  logic        nack;
  logic        timeout;
  logic [1:0]  state_dbg;

  cmd_host #(.ENTRIES(ENTRIES), .LOG2(LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_cmd    (snd_cmd),
    .cmd        (cmd),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .resp       (resp),
    .resp_vld   (resp_vld),
    .cmd_cmplt  (cmd_cmplt),
    .busy       (busy),
    .ack        (ack),
    .nack       (nack),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         nvld;
    bit         ack;
    bit         nack;
    bit         to;
    logic [7:0] resp;
  } res_t;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  first;
    int          stp;
    int          nrep;
    bit          ack;
    bit          nack;
    logic [7:0]  resp;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rep_q[$];
  int         n_vld, n_cmplt, n_clr, cmplt_cyc;
  logic       cmplt_ack, cmplt_nack, cmplt_to, cmplt_busy;
  logic [7:0] cmplt_resp;
  logic [7:0] cur_resp = 8'h00;

  always @(negedge clk) begin
    if (trmt) tx_q.push_back(tx_data);
    if (resp_vld) n_vld++;
    if (clr_rx_rdy) n_clr++;
    if (cmd_cmplt) begin
      n_cmplt++;
      cmplt_cyc  = cyc;
      cmplt_ack  = ack;
      cmplt_nack = nack;
      cmplt_to   = timeout;
      cmplt_busy = busy;
      cmplt_resp = resp;
    end
    cyc++;
  end

  // ---------------- reference model ----------------
  // A command expects one reply, a dump expects ENTRIES; too few replies means a timeout.
  function automatic res_t model(input logic [15:0] c, input logic [7:0] r[$], input logic [7:0] prev);
    res_t m;
    int   need;
    logic [7:0] last;
    need = (c[15:14] == 2'b10) ? ENTRIES : 1;
    m.ack = 0; m.nack = 0; m.to = 0;
    if (r.size() < need) begin
      m.to   = 1;
      m.nvld = r.size();
      m.resp = (r.size() > 0) ? r[r.size()-1] : prev;
    end else begin
      last   = r[need-1];
      m.nvld = need;
      m.resp = last;
      if (need == 1) begin
        m.ack  = (last == 8'hA5);
        m.nack = (last == 8'hEE);
      end
    end
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] c);
    tx_q.delete(); exp_q.delete();
    n_vld = 0; n_cmplt = 0; n_clr = 0;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    snd_cmd = 1'b1; cmd = c;
    step();
    snd_cmd = 1'b0; cmd = 16'($urandom);
  endtask

  // Two transmit phases, each with a stray rx byte and an ignored snd_cmd while busy.
  task automatic tx_phase(output int rx_start);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 20; i++) begin
        rx_rdy  = (i == 5);
        rx_data = 8'h33;
        snd_cmd = (i == 9);
        cmd     = 16'($urandom);
        step();
      end
      rx_rdy = 1'b0; snd_cmd = 1'b0;
      tx_done = 1'b1;
      rx_start = cyc + 1;
      step();
      tx_done = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output int c);
    rx_rdy = 1'b1; rx_data = d; c = cyc;
    step();
    rx_rdy = 1'b0;
  endtask

  task automatic wait_cmplt(input string tag, input int budget);
    int i = 0;
    while (n_cmplt == 0 && i < budget) begin
      step();
      i++;
    end
    chk({tag, " cmplt_seen"}, (n_cmplt != 0), 1);
    step(2);
  endtask

  task automatic check_txn(input string tag, input res_t e, input int exp_cyc, input int nrep);
    chk({tag, " ntx"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) chk({tag, " tx_byte"}, tx_q[i], exp_q[i]);
    chk({tag, " n_resp_vld"}, n_vld, e.nvld);
    chk({tag, " n_clr"}, n_clr, nrep + 2);
    chk({tag, " n_cmplt"}, n_cmplt, 1);
    chk({tag, " ack"}, cmplt_ack, e.ack);
    chk({tag, " nack"}, cmplt_nack, e.nack);
    chk({tag, " timeout"}, cmplt_to, e.to);
    chk({tag, " resp"}, cmplt_resp, e.resp);
    chk({tag, " cmplt_cycle"}, cmplt_cyc, exp_cyc);
    chk({tag, " busy_at_cmplt"}, cmplt_busy, 1);
    chk({tag, " busy_after"}, busy, 0);
    cur_resp = e.resp;
  endtask

  // Full transaction using the replies queued in rep_q.
  task automatic run_txn(input string tag, input logic [15:0] c, input res_t e, input int max_gap);
    int rs, last_c, gap;
    start_cmd(c);
    tx_phase(rs);
    last_c = -1;
    foreach (rep_q[i]) begin
      gap = $urandom_range(0, max_gap);
      step(gap);
      send_byte(rep_q[i], last_c);
    end
    wait_cmplt(tag, TIMEOUT + 40);
    check_txn(tag, e, (rep_q.size() == 0) ? rs + TIMEOUT : last_c + 1, rep_q.size());
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " tx_data"}, tx_data, 0);
    chk({tag, " trmt"}, trmt, 0);
    chk({tag, " clr_rx_rdy"}, clr_rx_rdy, 0);
    chk({tag, " resp"}, resp, 0);
    chk({tag, " resp_vld"}, resp_vld, 0);
    chk({tag, " cmd_cmplt"}, cmd_cmplt, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ack"}, ack, 0);
    chk({tag, " nack"}, nack, 0);
    chk({tag, " timeout"}, timeout, 0);
    chk({tag, " state"}, state_dbg, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[6];
    res_t e;
    int   rs, c, op;
    logic [15:0] rc;
    logic [7:0]  tail;

    vecs[0] = '{16'h4706, 8'hA5, 0, 1,       1'b1, 1'b0, 8'hA5};
    vecs[1] = '{16'h0700, 8'hAA, 0, 1,       1'b0, 1'b0, 8'hAA};
    vecs[2] = '{16'h8100, 8'h00, 1, ENTRIES, 1'b0, 1'b0, 8'h7F};
    vecs[3] = '{16'hC000, 8'hEE, 0, 1,       1'b0, 1'b1, 8'hEE};
    vecs[4] = '{16'h8000, 8'hA5, 0, ENTRIES, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{16'h4000, 8'h12, 0, 1,       1'b0, 1'b0, 8'h12};

    rst_n = 1'b0; snd_cmd = 1'b0; cmd = 16'h0; tx_done = 1'b0; rx_rdy = 1'b0; rx_data = 8'h0;
    step(3);
    rst_n = 1'b1;
    check_reset_vals("reset");

    // stray byte in IDLE: acknowledged, never reported
    rx_rdy = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    chk("idle_rx clr_rx_rdy", clr_rx_rdy, 1);
    chk("idle_rx resp_vld", resp_vld, 0);
    step();
    rx_rdy = 1'b0;

    // table-driven transactions
    foreach (vecs[k]) begin
      rep_q.delete();
      for (int i = 0; i < vecs[k].nrep; i++) rep_q.push_back(8'(vecs[k].first + i * vecs[k].stp));
      e = '{vecs[k].nrep, vecs[k].ack, vecs[k].nack, 1'b0, vecs[k].resp};
      run_txn($sformatf("vec%0d", k), vecs[k].cmd, e, (vecs[k].nrep > 1) ? 1 : 2);
    end

    // timeout with no reply: cmd_cmplt TIMEOUT cycles after entering RX
    rep_q.delete();
    e = '{0, 1'b0, 1'b0, 1'b1, cur_resp};
    run_txn("timeout", 16'h0123, e, 0);

    // reply on the terminal idle cycle wins over the timeout
    start_cmd(16'h0321);
    tx_phase(rs);
    step(TIMEOUT - 1);
    send_byte(8'h5A, c);
    wait_cmplt("tc_byte", 20);
    e = '{1, 1'b0, 1'b0, 1'b0, 8'h5A};
    check_txn("tc_byte", e, c + 1, 1);

    // randomized transactions against the model
    for (int t = 0; t < 12; t++) begin
      op = $urandom_range(0, 3);
      if (op == 2 && $urandom_range(0, 2) != 0) op = 0;
      rc = {2'(op), 14'($urandom)};
      rep_q.delete();
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 2))
          0:       tail = 8'hA5;
          1:       tail = 8'hEE;
          default: tail = 8'($urandom);
        endcase
        for (int i = 0; i < ((op == 2) ? ENTRIES - 1 : 0); i++) rep_q.push_back(8'($urandom));
        rep_q.push_back(tail);
      end
      e = model(rc, rep_q, cur_resp);
      run_txn($sformatf("rand%0d", t), rc, e, (op == 2) ? 1 : 3);
    end

    // reset in the middle of a dump, after 100 bytes
    start_cmd(16'h8100);
    tx_phase(rs);
    for (int i = 0; i < 100; i++) send_byte(8'(i), c);
    chk("middump n_resp_vld", n_vld, 100);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_vals("middump");
    step(5);
    chk("middump no_cmplt", n_cmplt, 0);
    cur_resp = 8'h00;

    rep_q.delete();
    rep_q.push_back(8'hA5);
    e = '{1, 1'b1, 1'b0, 1'b0, 8'hA5};
    run_txn("post_reset_write", 16'h4706, e, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
